// File: rtl/mem_pkg.sv
// Shared definitions for the small register-file family.
// Holds the clear-sequencer state encoding and default geometry constants.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int unsigned MEM_WIDTH_DEF = 8;
  localparam int unsigned MEM_DEPTH_DEF = 8;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer for reg_file_2r1w: walks every entry from 0 to DEPTH-1,
// one per cycle, asking the storage array to load its reset value.
// Ports:
//   clk      - clock
//   Re       - asynchronous active-low reset
//   clr_req  - start request, honoured only in IDLE
//   clr_we   - write strobe for the entry at clr_addr
//   clr_addr - entry being cleared this cycle
//   clr_busy - high while entries are being cleared
//   clr_done - one-cycle pulse after the sequence completes
module reg_file_clr_seq
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Re,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              done_q;

  // busy_q tracks the CLEAR state exactly; done_q is raised on the cycle
  // spent in DONE so the pulse appears one edge after busy falls.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr_q == LAST_IDX) begin
            state_q <= DONE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one write port, two registered read ports with
// same-edge write forwarding, plus a hardware clear sequence.
// Ports:
//   clk            - clock
//   Re             - asynchronous active-low reset
//   we/waddr/wdata - write port (ignored while clr_busy, dropped if out of range)
//   raddr0/rdata0  - read port 0, one-cycle latency, out-of-range reads give 0
//   raddr1/rdata1  - read port 1, same behaviour as port 0
//   clr_req        - start a clear of all entries back to RESET_VAL
//   clr_busy       - clear in progress
//   clr_done       - one-cycle completion pulse
module reg_file_2r1w
  import mem_pkg::*;
#(
  parameter int unsigned      WIDTH     = MEM_WIDTH_DEF,
  parameter int unsigned      DEPTH     = MEM_DEPTH_DEF,
  parameter int unsigned      ADDR_W    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              Re,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [WIDTH-1:0]  rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rdata0_q, rdata0_d;
  logic [WIDTH-1:0]  rdata1_q, rdata1_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              waddr_ok, raddr0_ok, raddr1_ok;

  reg_file_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .Re       (Re),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  assign waddr_ok  = ({1'b0, waddr}  < DEPTH_EXT);
  assign raddr0_ok = ({1'b0, raddr0} < DEPTH_EXT);
  assign raddr1_ok = ({1'b0, raddr1} < DEPTH_EXT);

  // Single effective write port: the sequencer owns it while busy, so the
  // forwarding below sees RESET_VAL for entries cleared this edge.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    if (clr_busy) begin
      wr_en   = clr_we;
      wr_addr = clr_addr;
      wr_data = RESET_VAL;
    end else if (we && waddr_ok) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    rdata0_d = '0;
    if (raddr0_ok) begin
      rdata0_d = (wr_en && (wr_addr == raddr0)) ? wr_data : mem_q[raddr0];
    end
    rdata1_d = '0;
    if (raddr1_ok) begin
      rdata1_d = (wr_en && (wr_addr == raddr1)) ? wr_data : mem_q[raddr1];
    end
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      rdata0_q <= RESET_VAL;
      rdata1_q <= RESET_VAL;
    end else begin
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  logic Re  = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default 8x8
  logic       we = 0, clr_req = 0;
  logic [2:0] waddr = 0, raddr0 = 0, raddr1 = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata0, rdata1;
  logic       clr_busy, clr_done;

  // DUT B: 16-bit x 5 entries
  logic        b_we = 0, b_clr_req = 0;
  logic [2:0]  b_waddr = 0, b_raddr0 = 0, b_raddr1 = 0;
  logic [15:0] b_wdata = 0;
  logic [15:0] b_rdata0, b_rdata1;
  logic        b_busy, b_done;

  reg_file_2r1w dut_a (
    .clk(clk), .Re(Re), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(5)) dut_b (
    .clk(clk), .Re(Re), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .raddr0(b_raddr0), .rdata0(b_rdata0), .raddr1(b_raddr1), .rdata1(b_rdata1),
    .clr_req(b_clr_req), .clr_busy(b_busy), .clr_done(b_done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model for DUT A: contents array plus the edge number at which
  // the last clear request was accepted. Entry j is cleared at edge k+1+j,
  // busy is seen after edges k..k+7, done after edge k+9.
  logic [7:0] mdl [8];
  int         cyc = 0;
  bit         act = 0;
  int         k   = 0;
  logic [7:0] exp_rd0, exp_rd1;
  logic       exp_busy, exp_done;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    act = 0;
  endtask

  task automatic cycle();
    int         c;
    bit         wen;
    int         widx;
    logic [7:0] wval;
    c    = cyc + 1;
    wen  = 0;
    widx = 0;
    wval = 8'h00;
    if (act && c >= k + 1 && c <= k + 8) begin
      wen = 1; widx = c - k - 1; wval = 8'h00;
    end else if (we) begin
      wen = 1; widx = int'(waddr); wval = wdata;
    end
    exp_rd0 = (wen && widx == int'(raddr0)) ? wval : mdl[raddr0];
    exp_rd1 = (wen && widx == int'(raddr1)) ? wval : mdl[raddr1];
    if (clr_req && !(act && c <= k + 9)) begin
      act = 1; k = c;
    end
    if (wen) mdl[widx] = wval;
    exp_busy = act && c >= k && c < k + 8;
    exp_done = act && c == k + 9;
    @(posedge clk);
    cyc = c;
    #1;
  endtask

  task automatic test_reset();
    Re = 1'b0;
    model_reset();
    #50;
    total++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      bad++; $display("FAIL reset_rdata: got %h/%h expected 00/00", rdata0, rdata1);
    end
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", clr_busy, clr_done);
    end
    @(negedge clk);
    Re = 1'b1;
    raddr0 = 3'd0; raddr1 = 3'd7;
    cycle();
    total++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      bad++; $display("FAIL reset_read: got %h/%h expected 00/00", rdata0, rdata1);
    end
  endtask

  task automatic test_write_read();
    we = 1; waddr = 3'd3; wdata = 8'hA5; raddr0 = 3'd0; raddr1 = 3'd1;
    cycle();
    we = 0; raddr0 = 3'd3; raddr1 = 3'd4;
    cycle();
    total++;
    if (rdata0 !== 8'hA5) begin
      bad++; $display("FAIL write_read_p0: got %h expected a5", rdata0);
    end
    total++;
    if (rdata1 !== 8'h00) begin
      bad++; $display("FAIL write_read_p1: got %h expected 00", rdata1);
    end
  endtask

  task automatic test_bypass();
    we = 1; waddr = 3'd5; wdata = 8'h3C; raddr0 = 3'd5; raddr1 = 3'd5;
    cycle();
    total++;
    if (rdata0 !== 8'h3C || rdata1 !== 8'h3C) begin
      bad++; $display("FAIL bypass_both: got %h/%h expected 3c/3c", rdata0, rdata1);
    end
    we = 0; raddr0 = 3'd5; raddr1 = 3'd3;
    cycle();
    total++;
    if (rdata0 !== 8'h3C || rdata1 !== 8'hA5) begin
      bad++; $display("FAIL bypass_stored: got %h/%h expected 3c/a5", rdata0, rdata1);
    end
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt;
    for (int i = 0; i < 8; i++) begin
      we = 1; waddr = 3'(i); wdata = 8'hFF;
      cycle();
    end
    we = 0; clr_req = 1;
    cycle();
    clr_req = 0;
    busy_cnt = clr_busy ? 1 : 0;
    done_cnt = clr_done ? 1 : 0;
    for (int j = 1; j <= 12; j++) begin
      we = (j == 3); waddr = 3'd2; wdata = 8'h11;
      raddr0 = 3'($urandom_range(0, 7)); raddr1 = 3'd2;
      cycle();
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      total++;
      if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1 || clr_busy !== exp_busy || clr_done !== exp_done) begin
        bad++;
        $display("FAIL clear_live: got %h/%h b=%b d=%b expected %h/%h b=%b d=%b",
                 rdata0, rdata1, clr_busy, clr_done, exp_rd0, exp_rd1, exp_busy, exp_done);
      end
    end
    we = 0;
    total++;
    if (busy_cnt != 8) begin
      bad++; $display("FAIL clear_busy_len: got %0d expected 8", busy_cnt);
    end
    total++;
    if (done_cnt != 1) begin
      bad++; $display("FAIL clear_done_cnt: got %0d expected 1", done_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      raddr0 = 3'(i); raddr1 = 3'(7 - i);
      cycle();
      total++;
      if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
        bad++; $display("FAIL clear_result: addr %0d got %h/%h expected 00/00", i, rdata0, rdata1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we      = ($urandom_range(0, 2) != 0);
      waddr   = 3'($urandom);
      wdata   = 8'($urandom);
      raddr0  = 3'($urandom);
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom);
      clr_req = ($urandom_range(0, 39) == 0);
      cycle();
      total++;
      if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1 || clr_busy !== exp_busy || clr_done !== exp_done) begin
        bad++;
        $display("FAIL random[%0d]: got %h/%h b=%b d=%b expected %h/%h b=%b d=%b", n,
                 rdata0, rdata1, clr_busy, clr_done, exp_rd0, exp_rd1, exp_busy, exp_done);
      end
    end
    we = 0; clr_req = 0;
    for (int n = 0; n < 12; n++) cycle();
  endtask

  task automatic test_reset_mid_clear();
    int done_seen;
    for (int i = 0; i < 8; i++) begin
      we = 1; waddr = 3'(i); wdata = 8'($urandom_range(1, 255));
      cycle();
    end
    we = 0; clr_req = 1;
    cycle();
    clr_req = 0;
    repeat (3) cycle();
    #2;
    Re = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      bad++; $display("FAIL midclr_async: got busy=%b done=%b expected 0/0", clr_busy, clr_done);
    end
    model_reset();
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (clr_done) done_seen++;
    end
    Re = 1'b1;
    for (int n = 0; n < 12; n++) begin
      raddr0 = 3'(n % 8); raddr1 = 3'(7 - (n % 8));
      cycle();
      if (clr_done) done_seen++;
      total++;
      if (rdata0 !== 8'h00 || rdata1 !== 8'h00 || clr_busy !== 1'b0) begin
        bad++; $display("FAIL midclr_after: got %h/%h busy=%b expected 00/00 busy=0", rdata0, rdata1, clr_busy);
      end
    end
    total++;
    if (done_seen != 0) begin
      bad++; $display("FAIL midclr_done: got %0d pulses expected 0", done_seen);
    end
  endtask

  task automatic test_param_sweep();
    logic [15:0] bm [5];
    int busy_cnt, done_cnt;
    for (int i = 0; i < 5; i++) bm[i] = 16'h0000;
    b_we = 1; b_waddr = 3'd6; b_wdata = 16'hBEEF;
    cycle();
    b_we = 0;
    for (int i = 0; i < 5; i++) begin
      b_raddr0 = 3'(i); b_raddr1 = 3'd6;
      cycle();
      total++;
      if (b_rdata0 !== 16'h0000 || b_rdata1 !== 16'h0000) begin
        bad++; $display("FAIL sweep_oor: addr %0d got %h/%h expected 0000/0000", i, b_rdata0, b_rdata1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      bm[i] = 16'($urandom);
      b_we = 1; b_waddr = 3'(i); b_wdata = bm[i];
      cycle();
    end
    b_we = 0;
    for (int i = 0; i < 5; i++) begin
      b_raddr0 = 3'(i); b_raddr1 = 3'((i + 1) % 5);
      cycle();
      total++;
      if (b_rdata0 !== bm[i] || b_rdata1 !== bm[(i + 1) % 5]) begin
        bad++; $display("FAIL sweep_rw: addr %0d got %h/%h expected %h/%h", i,
                        b_rdata0, b_rdata1, bm[i], bm[(i + 1) % 5]);
      end
    end
    b_raddr1 = 3'd7;
    b_clr_req = 1;
    cycle();
    b_clr_req = 0;
    busy_cnt = b_busy ? 1 : 0;
    done_cnt = b_done ? 1 : 0;
    repeat (10) begin
      cycle();
      if (b_busy) busy_cnt++;
      if (b_done) done_cnt++;
    end
    total++;
    if (busy_cnt != 5 || done_cnt != 1) begin
      bad++; $display("FAIL sweep_clear: got busy=%0d done=%0d expected 5/1", busy_cnt, done_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      b_raddr0 = 3'(i);
      cycle();
      total++;
      if (b_rdata0 !== 16'h0000 || b_rdata1 !== 16'h0000) begin
        bad++; $display("FAIL sweep_cleared: addr %0d got %h/%h expected 0000/0000", i, b_rdata0, b_rdata1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_random();
    test_reset_mid_clear();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file with one write port and two read ports, successor to the single-bit D latch with reset in Memory_Structures.
- Generalises width and depth, registers the read data, and forwards same-cycle writes to the read ports.
- Adds a hardware clear sequencer that walks every entry back to the reset value on request.
- Used as small scratch storage by datapath blocks.

Parameters:
- WIDTH, 8, data bits per entry (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of 2)
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- RESET_VAL, 0, value loaded into every entry by reset and by the clear sequence

Ports:
- clk  in  1  clock; all state changes on rising edge except reset
- Re  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- raddr0  in  ADDR_W  read address, port 0
- rdata0  out  WIDTH  registered read data, port 0
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  WIDTH  registered read data, port 1
- clr_req  in  1  start-clear request, sampled on rising edge
- clr_busy  out  1  high while the clear sequence is running
- clr_done  out  1  one-cycle pulse when the clear sequence finishes

Behaviour:
- Reset (Re=0, asynchronous):
  - all entries = RESET_VAL
  - rdata0 = rdata1 = RESET_VAL
  - clr_busy = 0, clr_done = 0
  - FSM = IDLE, clear pointer = 0
- Write: when we=1, not clr_busy and waddr<DEPTH, mem[waddr] <= wdata at the rising edge.
  - Writes with waddr>=DEPTH are dropped.
- Read: latency 1 cycle. rdataN at edge k+1 reflects raddrN at edge k.
  - raddrN>=DEPTH returns 0.
- Bypass: if the write performed at the same edge targets raddrN, rdataN takes the written value (wdata, or RESET_VAL during clear), not the old contents.
  - Both ports may bypass simultaneously.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, pointer=0, clr_busy=1 from the next cycle.
  - CLEAR: each cycle mem[pointer] <= RESET_VAL, pointer++.
    - After writing entry DEPTH-1 -> DONE.
    - Takes exactly DEPTH cycles.
  - DONE: clr_busy=0, clr_done=1 for exactly one cycle -> IDLE.
  - Total latency: clr_req sampled at edge k, clr_done high from edge k+DEPTH+1 to edge k+DEPTH+2.
- Arbitration:
  - While clr_busy, external writes are ignored, with no error flag.
  - clr_req is ignored in CLEAR and DONE.
  - A write presented in the same cycle that clr_req is sampled in IDLE is performed; its entry is cleared later by the sequence.
- Reads remain live during clear. An entry not yet reached returns its old value; an entry already cleared returns RESET_VAL.
- Pointer never exceeds DEPTH-1; no wrap into out-of-range entries for non-power-of-2 DEPTH.
- Reset mid-clear aborts the sequence; state is as in reset, and clr_done does not pulse.
- Inputs are assumed synchronous to clk. No internal latches: all storage is flip-flops.

Decomposition:
- Shared package mem_pkg:
  - FSM state enum (IDLE, CLEAR, DONE)
  - default WIDTH/DEPTH constants
- Natural sub-module: reg_file_clr_seq, holding the clear FSM and pointer.
  - Outputs: clr_we, clr_addr, clr_busy, clr_done.
  - The top level muxes clr_we/clr_addr/RESET_VAL over the external write port.
- Storage array, read registers and bypass stay in the top level.

Test Plan:
1. Reset then read: hold Re=0 for 50 ns, release, read addresses 0 and 7 -> rdata0 = rdata1 = 8'h00 one cycle later.
2. Write/read: write 8'hA5 to addr 3, then read addr 3 on port 0 and addr 4 on port 1 next cycle -> rdata0 = 8'hA5, rdata1 = 8'h00.
3. Bypass: at one edge, we=1, waddr=5, wdata=8'h3C, raddr0 = raddr1 = 5 -> both rdata = 8'h3C after that edge; mem[5] = 8'h3C.
4. Clear sequence: fill all 8 entries with 8'hFF, pulse clr_req -> clr_busy high for 8 cycles, clr_done pulses once, every entry reads 8'h00. A write of 8'h11 to addr 2 during busy is dropped.
5. Reset mid-clear: assert Re=0 asynchronously 3 cycles into CLEAR (between edges) -> clr_busy drops immediately, clr_done never pulses, all entries read 8'h00.
6. Parameter sweep: WIDTH=16, DEPTH=5. Write addr 6 with we=1 -> no entry changes. Read addr 6 -> 16'h0000. Clear takes 5 cycles.
